aes_gcm_spi_regif: RTL

Parametrised SPI mode-0 slave register interface for the AES-GCM engine. It replaces the fixed-geometry SPI wrapper. Key, nonce, plaintext block count and AAD length are set by parameters. The host gets a sticky status/error byte, a maskable interrupt, and zero-padded over-reads. The block sits between the external SPI pins and the `aes_gcm_top` core. It drives the core's flat input buses and `start` pulse, and captures the core's results on `done`.

---
 rtl/aes_gcm_spi_regif.sv | 296 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/aes_gcm_spi_regif.sv
// SPI mode-0 slave register file for the AES-GCM core: field writes, result reads,
// sticky status/error byte and a maskable level interrupt.
module aes_gcm_spi_regif #(
    parameter int KEY_BYTES   = 32,
    parameter int NONCE_BYTES = 12,
    parameter int PT_BLOCKS   = 3,
    parameter int AAD_BYTES   = 28,
    parameter int SYNC_STAGES = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       spi_sck,
    input  logic                       spi_mosi,
    input  logic                       spi_cs_n,
    output logic                       spi_miso,
    output logic                       irq,
    output logic                       core_start,
    output logic [8*KEY_BYTES-1:0]     core_key,
    output logic [8*NONCE_BYTES-1:0]   core_nonce,
    output logic [128*PT_BLOCKS-1:0]   core_pt,
    output logic [8*AAD_BYTES-1:0]     core_aad,
    input  logic [128*PT_BLOCKS-1:0]   core_ct,
    input  logic [127:0]               core_tag,
    input  logic                       core_done
);
    localparam int PT_BYTES = 16 * PT_BLOCKS;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WRITE   = 2'd1;
    localparam logic [1:0] ST_READ    = 2'd2;
    localparam logic [1:0] ST_DISCARD = 2'd3;

    localparam logic [7:0] CMD_KEY    = 8'h01;
    localparam logic [7:0] CMD_NONCE  = 8'h02;
    localparam logic [7:0] CMD_PT     = 8'h03;
    localparam logic [7:0] CMD_AAD    = 8'h04;
    localparam logic [7:0] CMD_START  = 8'h10;
    localparam logic [7:0] CMD_CT     = 8'h20;
    localparam logic [7:0] CMD_TAG    = 8'h21;
    localparam logic [7:0] CMD_IRQEN  = 8'h30;
    localparam logic [7:0] CMD_STATUS = 8'hF0;

    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic                   armed_q, armed_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [6:0]             rx_shift_q, rx_shift_d;
    logic                   byte_rdy_q, byte_rdy_d;
    logic [7:0]             rx_byte_q, rx_byte_d;
    logic [1:0]             state_q, state_d;
    logic [7:0]             cmd_q, cmd_d;
    logic [7:0]             byte_cnt_q, byte_cnt_d;
    logic [7:0]             tx_shift_q, tx_shift_d;
    logic                   miso_q, miso_d;
    logic                   irq_q, irq_d;
    logic                   core_start_q, core_start_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;
    logic                   err_q, err_d;
    logic                   irq_en_q, irq_en_d;

    logic [KEY_BYTES-1:0][7:0]   key_q, key_d;
    logic [NONCE_BYTES-1:0][7:0] nonce_q, nonce_d;
    logic [PT_BYTES-1:0][7:0]    pt_q, pt_d;
    logic [AAD_BYTES-1:0][7:0]   aad_q, aad_d;
    logic [PT_BYTES-1:0][7:0]    ct_sh_q, ct_sh_d;
    logic [15:0][7:0]            tag_sh_q, tag_sh_d;

    logic       cs_n_s, mosi_s, sck_rise, sck_fall, active;
    logic [7:0] rd_cmd, rd_idx, rd_data;
    logic       set_err, clr_err, set_busy, clr_done, wr_hit;

    assign cs_n_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_sync_q[SYNC_STAGES-2] & ~sck_sync_q[SYNC_STAGES-1];
    assign sck_fall = ~sck_sync_q[SYNC_STAGES-2] & sck_sync_q[SYNC_STAGES-1];
    // After reset the frame stays dead until CS is seen high again.
    assign active   = armed_q & ~cs_n_s;

    // Read mux: at decode time the command byte itself selects response byte 0.
    always_comb begin
        rd_cmd  = (state_q == ST_IDLE) ? rx_byte_q : cmd_q;
        rd_idx  = (state_q == ST_IDLE) ? 8'd0 : byte_cnt_q;
        rd_data = 8'h00;
        if (rd_cmd == CMD_CT) begin
            for (int i = 0; i < PT_BYTES; i++)
                if (rd_idx == 8'(i)) rd_data = ct_sh_q[PT_BYTES-1-i];
        end else if (rd_cmd == CMD_TAG) begin
            for (int i = 0; i < 16; i++)
                if (rd_idx == 8'(i)) rd_data = tag_sh_q[15-i];
        end
    end

    always_comb begin
        sck_sync_d   = {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
        mosi_sync_d  = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
        cs_sync_d    = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
        armed_d      = armed_q | cs_n_s;
        bit_cnt_d    = bit_cnt_q;
        rx_shift_d   = rx_shift_q;
        byte_rdy_d   = 1'b0;
        rx_byte_d    = rx_byte_q;
        state_d      = state_q;
        cmd_d        = cmd_q;
        byte_cnt_d   = byte_cnt_q;
        tx_shift_d   = tx_shift_q;
        miso_d       = miso_q;
        core_start_d = 1'b0;
        key_d        = key_q;
        nonce_d      = nonce_q;
        pt_d         = pt_q;
        aad_d        = aad_q;
        irq_en_d     = irq_en_q;
        set_err      = 1'b0;
        clr_err      = 1'b0;
        set_busy     = 1'b0;
        clr_done     = 1'b0;
        wr_hit       = 1'b0;

        if (!active) begin
            bit_cnt_d  = 3'd0;
            rx_shift_d = 7'd0;
            state_d    = ST_IDLE;
            byte_cnt_d = 8'd0;
            tx_shift_d = 8'd0;
            miso_d     = 1'b0;
        end else begin
            if (sck_rise) begin
                rx_shift_d = {rx_shift_q[5:0], mosi_s};
                bit_cnt_d  = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    byte_rdy_d = 1'b1;
                    rx_byte_d  = {rx_shift_q, mosi_s};
                end
            end
            if (sck_fall) begin
                miso_d     = tx_shift_q[7];
                tx_shift_d = {tx_shift_q[6:0], 1'b0};
            end
            if (byte_rdy_q) begin
                case (state_q)
                    ST_IDLE: begin
                        cmd_d = rx_byte_q;
                        case (rx_byte_q)
                            CMD_KEY, CMD_NONCE, CMD_PT, CMD_AAD, CMD_IRQEN: begin
                                state_d    = ST_WRITE;
                                byte_cnt_d = 8'd0;
                            end
                            CMD_START: begin
                                state_d = ST_DISCARD;
                                if (!busy_q) begin
                                    core_start_d = 1'b1;
                                    set_busy     = 1'b1;
                                    clr_done     = 1'b1;
                                end else begin
                                    set_err = 1'b1;
                                end
                            end
                            CMD_CT, CMD_TAG: begin
                                state_d    = ST_READ;
                                tx_shift_d = rd_data;
                                byte_cnt_d = 8'd1;
                            end
                            CMD_STATUS: begin
                                state_d    = ST_READ;
                                tx_shift_d = {4'b0, err_q, irq_en_q, busy_q, done_q};
                                byte_cnt_d = 8'd1;
                                clr_done   = 1'b1;
                                clr_err    = 1'b1;
                            end
                            default: begin
                                state_d = ST_DISCARD;
                                set_err = 1'b1;
                            end
                        endcase
                    end
                    ST_WRITE: begin
                        // Bytes beyond the field match no index and flag an error.
                        case (cmd_q)
                            CMD_KEY:
                                for (int i = 0; i < KEY_BYTES; i++)
                                    if (byte_cnt_q == 8'(i)) begin
                                        key_d[KEY_BYTES-1-i] = rx_byte_q;
                                        wr_hit = 1'b1;
                                    end
                            CMD_NONCE:
                                for (int i = 0; i < NONCE_BYTES; i++)
                                    if (byte_cnt_q == 8'(i)) begin
                                        nonce_d[NONCE_BYTES-1-i] = rx_byte_q;
                                        wr_hit = 1'b1;
                                    end
                            CMD_PT:
                                for (int i = 0; i < PT_BYTES; i++)
                                    if (byte_cnt_q == 8'(i)) begin
                                        pt_d[PT_BYTES-1-i] = rx_byte_q;
                                        wr_hit = 1'b1;
                                    end
                            CMD_AAD:
                                for (int i = 0; i < AAD_BYTES; i++)
                                    if (byte_cnt_q == 8'(i)) begin
                                        aad_d[AAD_BYTES-1-i] = rx_byte_q;
                                        wr_hit = 1'b1;
                                    end
                            default:
                                if (byte_cnt_q == 8'd0) begin
                                    irq_en_d = rx_byte_q[0];
                                    wr_hit   = 1'b1;
                                end
                        endcase
                        set_err    = ~wr_hit;
                        byte_cnt_d = (byte_cnt_q == 8'hFF) ? byte_cnt_q : byte_cnt_q + 8'd1;
                    end
                    ST_READ: begin
                        tx_shift_d = rd_data;
                        byte_cnt_d = (byte_cnt_q == 8'hFF) ? byte_cnt_q : byte_cnt_q + 8'd1;
                    end
                    default: ;
                endcase
            end
        end

        ct_sh_d  = core_done ? core_ct  : ct_sh_q;
        tag_sh_d = core_done ? core_tag : tag_sh_q;
        // Set events win over the status-read clear; START judges the registered busy.
        done_d   = core_done ? 1'b1 : (clr_done ? 1'b0 : done_q);
        busy_d   = set_busy  ? 1'b1 : (core_done ? 1'b0 : busy_q);
        err_d    = set_err   ? 1'b1 : (clr_err ? 1'b0 : err_q);
        irq_d    = done_q & irq_en_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync_q   <= '0;
            mosi_sync_q  <= '0;
            cs_sync_q    <= '0;
            armed_q      <= 1'b0;
            bit_cnt_q    <= 3'd0;
            rx_shift_q   <= 7'd0;
            byte_rdy_q   <= 1'b0;
            rx_byte_q    <= 8'd0;
            state_q      <= ST_IDLE;
            cmd_q        <= 8'd0;
            byte_cnt_q   <= 8'd0;
            tx_shift_q   <= 8'd0;
            miso_q       <= 1'b0;
            irq_q        <= 1'b0;
            core_start_q <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            irq_en_q     <= 1'b1;
            key_q        <= '0;
            nonce_q      <= '0;
            pt_q         <= '0;
            aad_q        <= '0;
            ct_sh_q      <= '0;
            tag_sh_q     <= '0;
        end else begin
            sck_sync_q   <= sck_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            cs_sync_q    <= cs_sync_d;
            armed_q      <= armed_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_shift_q   <= rx_shift_d;
            byte_rdy_q   <= byte_rdy_d;
            rx_byte_q    <= rx_byte_d;
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            byte_cnt_q   <= byte_cnt_d;
            tx_shift_q   <= tx_shift_d;
            miso_q       <= miso_d;
            irq_q        <= irq_d;
            core_start_q <= core_start_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            irq_en_q     <= irq_en_d;
            key_q        <= key_d;
            nonce_q      <= nonce_d;
            pt_q         <= pt_d;
            aad_q        <= aad_d;
            ct_sh_q      <= ct_sh_d;
            tag_sh_q     <= tag_sh_d;
        end
    end

    assign spi_miso   = miso_q;
    assign irq        = irq_q;
    assign core_start = core_start_q;
    assign core_key   = key_q;
    assign core_nonce = nonce_q;
    assign core_pt    = pt_q;
    assign core_aad   = aad_q;

endmodule
